// File: rtl/dcache_pkg.sv
// dcache_pkg: shared sizes, refill FSM states and store-buffer entry for the data-cache controller
package dcache_pkg;
  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W = 3;
  localparam int LINE_IDX_W = 7;
  localparam int ADDR_W = LINE_IDX_W + OFFSET_W;
  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} refill_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
    logic [3:0] ben;
  } store_entry_t;
endpackage

// File: rtl/refill_collector.sv
// refill_collector: gathers eight AXI read beats into a line buffer and requests a one-cycle commit
module refill_collector
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [LINE_IDX_W-1:0] line_in,
  input  logic beat_valid,
  input  logic [31:0] beat_data,
  input  logic beat_last,
  output logic beat_ready,
  output logic busy,
  output logic done,
  output logic err,
  output logic commit,
  output logic [LINE_IDX_W-1:0] line,
  output logic [LINE_WORDS*32-1:0] line_buf
);
  refill_state_e state, state_nx;
  logic [OFFSET_W-1:0] cnt;
  logic beat, last_word;
  always_comb begin
    beat = state == COLLECT && beat_valid;
    last_word = cnt == OFFSET_W'(LINE_WORDS - 1);
    state_nx = state == IDLE ? (start ? COLLECT : IDLE) :
               state == COLLECT ? ((beat && last_word) ? COMMIT : COLLECT) : IDLE;
    beat_ready = state == COLLECT;
    busy = state != IDLE;
    commit = state == COMMIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      line_buf <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == COMMIT;
      if (state == IDLE && start) begin
        line <= line_in;
        cnt <= '0;
      end
      if (beat) begin
        line_buf[32*cnt +: 32] <= beat_data;
        cnt <= cnt + 1'b1;
        if (beat_last != last_word) err <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/dcache_data_ctrl.sv
// dcache_data_ctrl: shares the line BRAM port between refill commits, store-buffer drains and loads
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic ld_ready,
  output logic ld_rvalid,
  output logic [31:0] ld_rdata,
  input  logic st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0] st_ben,
  output logic st_ready,
  input  logic rf_start,
  input  logic [LINE_IDX_W-1:0] rf_line,
  input  logic rf_beat_valid,
  input  logic [31:0] rf_beat_data,
  input  logic rf_beat_last,
  output logic rf_beat_ready,
  output logic rf_busy,
  output logic rf_done,
  output logic rf_err,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic bram_re,
  output logic bram_we,
  output logic bram_store,
  output logic bram_hit_write,
  output logic [31:0] bram_din,
  output logic [LINE_WORDS*32-1:0] bram_din_all,
  output logic [3:0] bram_byte_ben,
  input  logic [31:0] bram_dout
);
  store_entry_t sb;
  logic full, rf_commit, commit, drain, hazard;
  logic [LINE_IDX_W-1:0] rf_idx;
  refill_collector u_rc (
    .clk(clk),
    .rst(rst),
    .start(rf_start),
    .line_in(rf_line),
    .beat_valid(rf_beat_valid),
    .beat_data(rf_beat_data),
    .beat_last(rf_beat_last),
    .beat_ready(rf_beat_ready),
    .busy(rf_busy),
    .done(rf_done),
    .err(rf_err),
    .commit(rf_commit),
    .line(rf_idx),
    .line_buf(bram_din_all)
  );
  always_comb begin
    commit = rf_commit && !rst;
    drain = full && !commit && !rst;
    hazard = full && sb.addr == ld_addr;
    ld_ready = ld_valid && !commit && !drain && !hazard && !rst;
    st_ready = !full || drain;
    ld_rdata = bram_dout;
    bram_re = ld_ready;
    bram_raddr = ld_addr;
    bram_we = commit || drain;
    bram_store = drain;
    bram_hit_write = commit;
    bram_waddr = commit ? {rf_idx, {OFFSET_W{1'b0}}} : sb.addr;
    bram_din = sb.data;
    bram_byte_ben = drain ? sb.ben : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      sb <= '0;
      ld_rvalid <= 1'b0;
    end else begin
      ld_rvalid <= ld_ready;
      if (st_valid && st_ready) begin
        sb <= '{addr: st_addr, data: st_data, ben: st_ben};
        full <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dcache_data_ctrl.sv
// tb_dcache_data_ctrl: randomized and directed stimulus checked against a transaction-level cache model
module tb_dcache_data_ctrl;
  logic clk = 1'b0, rst;
  logic ld_valid, ld_ready, ld_rvalid;
  logic [9:0] ld_addr, st_addr, bram_raddr, bram_waddr;
  logic [31:0] ld_rdata, st_data, rf_beat_data, bram_din, bram_dout;
  logic [3:0] st_ben, bram_byte_ben;
  logic st_valid, st_ready, rf_start, rf_beat_valid, rf_beat_last, rf_beat_ready;
  logic rf_busy, rf_done, rf_err, bram_re, bram_we, bram_store, bram_hit_write;
  logic [6:0] rf_line;
  logic [255:0] bram_din_all;
  always #5 clk = ~clk;
  dcache_data_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ben(st_ben), .st_ready(st_ready),
    .rf_start(rf_start), .rf_line(rf_line), .rf_beat_valid(rf_beat_valid),
    .rf_beat_data(rf_beat_data), .rf_beat_last(rf_beat_last), .rf_beat_ready(rf_beat_ready),
    .rf_busy(rf_busy), .rf_done(rf_done), .rf_err(rf_err),
    .bram_raddr(bram_raddr), .bram_waddr(bram_waddr), .bram_re(bram_re), .bram_we(bram_we),
    .bram_store(bram_store), .bram_hit_write(bram_hit_write), .bram_din(bram_din),
    .bram_din_all(bram_din_all), .bram_byte_ben(bram_byte_ben), .bram_dout(bram_dout)
  );
  function automatic logic [31:0] init_word(int i);
    return i == 'h13 ? 32'hDEADBEEF : (i * 32'h01000193) ^ 32'hC0FFEE00;
  endfunction
  logic [31:0] pmem [1024];
  logic loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) pmem[i] <= init_word(i);
      loaded <= 1'b1;
    end else begin
      if (bram_re) bram_dout <= pmem[bram_raddr];
      if (bram_we && bram_store)
        for (int b = 0; b < 4; b++)
          if (bram_byte_ben[b]) pmem[bram_waddr][8*b +: 8] <= bram_din[8*b +: 8];
      if (bram_we && bram_hit_write)
        for (int i = 0; i < 8; i++) pmem[{bram_waddr[9:3], 3'(i)}] <= bram_din_all[32*i +: 32];
    end
  end
  int n_chk = 0, n_err = 0;
  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [31:0] ref_mem [1024];
  int phase = 0, nb = 0;
  logic [6:0] rline;
  logic [31:0] lbuf [8];
  logic merr = 0, mdone = 0, sbv = 0, rv = 0;
  logic [9:0] sba;
  logic [31:0] sbd, rd;
  logic [3:0] sbb;
  task automatic step(bit ldv, logic [9:0] lda, bit stv, logic [9:0] sta, logic [31:0] std,
                      logic [3:0] stb, bit rfs, logic [6:0] rfl, bit bv, logic [31:0] bd, bit bl, bit r);
    bit c_commit, c_drain, c_ld, c_st;
    logic [255:0] line_exp;
    ld_valid = ldv; ld_addr = lda; st_valid = stv; st_addr = sta; st_data = std; st_ben = stb;
    rf_start = rfs; rf_line = rfl; rf_beat_valid = bv; rf_beat_data = bd; rf_beat_last = bl; rst = r;
    @(negedge clk);
    c_commit = !r && phase == 2;
    c_drain = !r && sbv && !c_commit;
    c_ld = !r && ldv && !c_commit && !c_drain && !(sbv && sba == lda);
    c_st = !sbv || c_drain;
    for (int i = 0; i < 8; i++) line_exp[32*i +: 32] = lbuf[i];
    chk("bram_we", bram_we, c_commit || c_drain);
    chk("bram_re", bram_re, c_ld);
    if (!r) begin
      chk("ld_ready", ld_ready, c_ld);
      chk("st_ready", st_ready, c_st);
      chk("rf_beat_ready", rf_beat_ready, phase == 1);
      chk("rf_busy", rf_busy, phase != 0);
      chk("rf_done", rf_done, mdone);
      chk("rf_err", rf_err, merr);
      chk("ld_rvalid", ld_rvalid, rv);
      chk("bram_store", bram_store, c_drain);
      chk("bram_hit_write", bram_hit_write, c_commit);
      if (rv) chk("ld_rdata", ld_rdata, rd);
      if (c_ld) chk("bram_raddr", bram_raddr, lda);
      if (c_drain) begin
        chk("drain_waddr", bram_waddr, sba);
        chk("drain_din", bram_din, sbd);
        chk("drain_ben", bram_byte_ben, sbb);
      end
      if (c_commit) begin
        chk("commit_waddr", bram_waddr, {rline, 3'b000});
        chk("commit_din_all", bram_din_all, line_exp);
      end
    end
    @(posedge clk);
    if (r) begin
      phase = 0; nb = 0; merr = 0; mdone = 0; sbv = 0; rv = 0;
    end else begin
      rv = c_ld;
      if (c_ld) rd = ref_mem[lda];
      mdone = phase == 2;
      if (c_drain) begin
        for (int b = 0; b < 4; b++) if (sbb[b]) ref_mem[sba][8*b +: 8] = sbd[8*b +: 8];
        sbv = 0;
      end
      if (stv && c_st) begin
        sbv = 1; sba = sta; sbd = std; sbb = stb;
      end
      if (phase == 2) begin
        for (int i = 0; i < 8; i++) ref_mem[{rline, 3'(i)}] = lbuf[i];
        phase = 0;
      end else if (phase == 1 && bv) begin
        lbuf[nb] = bd;
        if (bl != (nb == 7)) merr = 1;
        nb++;
        if (nb == 8) phase = 2;
      end else if (phase == 0 && rfs) begin
        phase = 1; nb = 0; rline = rfl;
      end
    end
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic refill(logic [6:0] l, logic [31:0] base, int last_at);
    step(0, 0, 0, 0, 0, 0, 1, l, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, base + i, i == last_at, 0);
  endtask
  function automatic logic [9:0] pick_addr();
    int k = $urandom_range(0, 12);
    return k < 4 ? 10'h020 + 10'(k) : k < 12 ? 10'h028 + 10'(k - 4) : 10'h013;
  endfunction
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 8; i++) lbuf[i] = '0;
    rline = '0; sba = '0; sbd = '0; sbb = '0; rd = '0;
    @(posedge clk); #1;
    step(1, 'h013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    step(1, 'h013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 1, 'h020, 32'h11223344, 4'b0011, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 'h020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    refill(7'd5, 32'h100, 7);
    idle(); idle();
    step(1, 'h02A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    refill(7'd4, 32'h200, 3);
    idle(); idle();
    step(1, 'h020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 7'd5, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300 + i, 0, 0);
    step(0, 0, 1, 'h013, 32'hA5A5A5A5, 4'b1111, 0, 0, 1, 32'h307, 1, 0);
    repeat (3) step(1, 'h029, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 7'd4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400 + i, 0, 0);
    step(0, 0, 1, 'h021, 32'h55AA55AA, 4'b1111, 0, 0, 1, 32'h403, 0, 0);
    step(1, 'h022, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    refill(7'd4, 32'h500, 7);
    idle(); idle();
    step(1, 'h021, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int c = 0; c < 3000; c++) begin
      bit bl;
      bl = nb == 7 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 1), pick_addr(), $urandom_range(0, 9) < 4, pick_addr(), $urandom,
           4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 1) ? 7'd5 : 7'd4,
           $urandom_range(0, 9) < 7, $urandom, bl, $urandom_range(0, 199) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
